bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Four-master round-robin arbiter sharing one slave, with registered one-hot grant.
// Optional burst limit compiled in with `define BUS_ARBITER_BURST_LIMIT_EN.
module bus_arbiter #(
    parameter int SIZE      = 2,
    parameter int MAX_BURST = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [3:0]           req,
    input  logic [3:0][SIZE-1:0] m2s_in,
    input  logic [SIZE-1:0]      s2m_in,
    output logic [SIZE-1:0]      m2s_out,
    output logic [3:0][SIZE-1:0] s2m_out,
    output logic [3:0]           grant,
    output logic [1:0]           owner,
    output logic                 busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] last_q, last_d;
    logic [1:0] owner_d;
    logic [3:0] grant_d;
    logic       busy_d;

    logic [1:0] rr_winner;
    logic [1:0] rr_cand;
    logic       rr_found;
    logic       burst_expired;

    if (MAX_BURST < 2 || MAX_BURST > 256) begin : g_bad_max_burst
        $error("bus_arbiter: MAX_BURST must lie in 2..256");
    end

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        rr_winner = '0;
        rr_cand   = '0;
        rr_found  = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            rr_cand = last_q + 2'(i);
            if (!rr_found && req[rr_cand]) begin
                rr_winner = rr_cand;
                rr_found  = 1'b1;
            end
        end
    end

`ifdef BUS_ARBITER_BURST_LIMIT_EN
    localparam logic [7:0] burst_last = 8'(MAX_BURST - 1);

    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic       others_req;

    assign others_req    = |(req & ~(4'b0001 << owner));
    assign burst_expired = (burst_cnt_q == burst_last) && others_req;

    // Cleared on entry to GRANT, saturates so a lone requester keeps the bus.
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (state_q == IDLE) begin
            burst_cnt_d = '0;
        end else if (burst_cnt_q != burst_last) begin
            burst_cnt_d = burst_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    assign burst_expired = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner;
        grant_d = grant;
        busy_d  = busy;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    state_d = GRANT;
                    last_d  = rr_winner;
                    owner_d = rr_winner;
                    grant_d = 4'b0001 << rr_winner;
                    busy_d  = 1'b1;
                end
            end
            GRANT: begin
                // Only the owner's own request (or burst expiry) can end a grant.
                if (!req[owner] || burst_expired) begin
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together from pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            owner   <= '0;
            grant   <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner   <= owner_d;
            grant   <= grant_d;
            busy    <= busy_d;
        end
    end

    always_comb begin
        m2s_out = '0;
        s2m_out = '0;
        if (busy) begin
            m2s_out        = m2s_in[owner];
            s2m_out[owner] = s2m_in;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            assert ($onehot0(grant));
            assert (busy == (|grant));
        end
    end
`endif

endmodule
